// File: rtl/uart_tx_fifo_drain_if.sv
// FIFO read port plus serial-line status of the UART TX drain; the drain drives the master side.
// The FIFO/line owner (FIFO model, pad logic) connects through the slave side.
interface uart_tx_fifo_drain_if #(
  parameter int DATA_BITS = 8
);
  logic                 fifo_empty;
  logic                 fifo_rd_en;
  logic [DATA_BITS-1:0] fifo_rd_data;
  logic                 tx;
  logic                 busy;
  logic                 tx_done;

  modport master (
    input  fifo_empty, fifo_rd_data,
    output fifo_rd_en, tx, busy, tx_done
  );

  modport slave (
    output fifo_empty, fifo_rd_data,
    input  fifo_rd_en, tx, busy, tx_done
  );
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// Pops one byte per frame from a 1-cycle-latency FIFO and serializes it (start, LSB-first data, opt. parity, stop).
// tx falls 3 cycles after fifo_empty is seen low in IDLE; FIFO fill level is ignored until the frame ends.
module uart_tx_fifo_drain #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  uart_tx_fifo_drain_if.master  bus
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic              PAR_SENSE = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 rd_en_q, rd_en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 bit_end;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    par_d   = par_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    bit_end = (baud_q == BAUD_LAST);

    case (state_q)
      S_IDLE:   if (!bus.fifo_empty) state_d = S_FETCH;
      S_FETCH:  state_d = S_LOAD;
      S_LOAD: begin
        shift_d = bus.fifo_rd_data;
        par_d   = (^bus.fifo_rd_data) ^ PAR_SENSE;
        state_d = S_START;
      end
      S_START:  if (bit_end) state_d = S_DATA;
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == DATA_LAST) state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: if (bit_end) state_d = S_STOP;
      S_STOP:   if (bit_end && (idx_q == STOP_LAST)) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // The bit index doubles as the stop-bit counter, so it restarts on every state change.
    if ((state_d != state_q) || (state_q == S_IDLE)) begin
      baud_d = '0;
      idx_d  = '0;
    end else if (bit_end) begin
      baud_d = '0;
      idx_d  = idx_q + 1'b1;
    end else begin
      baud_d = baud_q + 1'b1;
    end

    // Outputs are decoded from the next state so they leave the flops aligned with it.
    rd_en_d = (state_d == S_FETCH);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_STOP) && (idx_d == STOP_LAST) && (baud_d == BAUD_LAST);
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.fifo_rd_en = rd_en_q;
  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Three drains (8N1, 8E2, 7O1) at 4 clocks/bit, each fed by a registered-read FIFO model.
// A per-cycle line-schedule model plus table vectors and directed reset/back-to-back/idle sequences.
module tb_uart_tx_fifo_drain;

  localparam int NCH = 3;
  localparam int CPB = 4;
  localparam int DB [NCH] = '{8, 8, 7};
  localparam int PE [NCH] = '{0, 1, 1};
  localparam int PO [NCH] = '{0, 0, 1};
  localparam int SB [NCH] = '{1, 2, 1};

  typedef struct packed { logic tx; logic busy; logic done; logic rd; } cyc_t;
  typedef struct { int ch; logic [7:0] data; logic exp_par; int exp_len; } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       empty_r   [NCH] = '{default: 1'b1};
  logic [7:0] rd_data_r [NCH] = '{default: 8'h00};
  logic       pop_req   [NCH] = '{default: 1'b0};
  logic       idle_pend [NCH] = '{default: 1'b0};
  int         pop_cnt   [NCH] = '{default: 0};
  int         push_cnt  [NCH] = '{default: 0};
  logic       tx_w [NCH], busy_w [NCH], done_w [NCH], rd_w [NCH];
  logic [7:0] fq    [NCH][$];
  cyc_t       sched [NCH][$];
  int         checks = 0;
  int         errs = 0;
  int         cyc = 0;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    uart_tx_fifo_drain_if #(.DATA_BITS(DB[g])) bus ();
    uart_tx_fifo_drain #(
      .CLKS_PER_BIT(CPB), .DATA_BITS(DB[g]), .PARITY_EN(PE[g]),
      .PARITY_ODD(PO[g]), .STOP_BITS(SB[g])
    ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    assign bus.fifo_empty   = empty_r[g];
    assign bus.fifo_rd_data = rd_data_r[g][DB[g]-1:0];
    assign tx_w[g]   = bus.tx;
    assign busy_w[g] = bus.busy;
    assign done_w[g] = bus.tx_done;
    assign rd_w[g]   = bus.fifo_rd_en;
  end

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mask(input int c);
    return 8'((1 << DB[c]) - 1);
  endfunction

  // Expected per-cycle line behaviour for one byte: fetch, load, frame bits, one idle cycle.
  function automatic void build(input int c, input logic [7:0] b);
    logic bq [$];
    bq.push_back(1'b0);
    for (int i = 0; i < DB[c]; i++) bq.push_back(b[i]);
    if (PE[c] != 0) bq.push_back((^(b & mask(c))) ^ (PO[c] != 0));
    for (int i = 0; i < SB[c]; i++) bq.push_back(1'b1);
    sched[c].push_back({1'b1, 1'b1, 1'b0, 1'b1});
    sched[c].push_back({1'b1, 1'b1, 1'b0, 1'b0});
    for (int k = 0; k < bq.size(); k++)
      for (int j = 0; j < CPB; j++)
        sched[c].push_back({bq[k], 1'b1, (k == bq.size() - 1) && (j == CPB - 1), 1'b0});
    sched[c].push_back({1'b1, 1'b0, 1'b0, 1'b0});
  endfunction

  always @(negedge clk) begin
    cyc++;
    for (int c = 0; c < NCH; c++) begin
      cyc_t e;
      empty_r[c] = (fq[c].size() == 0);
      pop_req[c] = rd_w[c];
      if (!rst_n) begin
        sched[c].delete();
        idle_pend[c] = 1'b0;
        e = 4'b1000;
      end else begin
        if ((sched[c].size() == 0) && idle_pend[c])
          build(c, (fq[c].size() != 0) ? fq[c][0] : 8'h00);
        if (sched[c].size() != 0) e = sched[c].pop_front();
        else e = 4'b1000;
        idle_pend[c] = !e.busy && (sched[c].size() == 0) && !empty_r[c];
      end
      chk($sformatf("ch%0d_line{tx,busy,done,rd}@cyc%0d", c, cyc),
          int'({tx_w[c], busy_w[c], done_w[c], rd_w[c]}), int'(e));
    end
  end

  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (pop_req[c]) begin
        logic [7:0] v;
        checks++;
        if (fq[c].size() == 0) begin
          errs++;
          $display("FAIL ch%0d_pop_while_empty: got rd_en=1 required 0", c);
        end else begin
          v = fq[c].pop_front();
          rd_data_r[c] <= v;
        end
        pop_cnt[c]++;
      end
    end
  end

  task automatic push(input int c, input logic [7:0] b);
    fq[c].push_back(b & mask(c));
    push_cnt[c]++;
  endtask

  task automatic wait_fall(input int c, input int limit, output int n);
    @(negedge clk);
    n = 0;
    while ((tx_w[c] !== 1'b0) && (n < limit)) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("ch%0d_start_seen", c), int'(n < limit), 1);
  endtask

  // Starts on the negedge of the first start-bit cycle; ends on the negedge after tx_done.
  task automatic capture(input int c, output logic [7:0] data, output logic par,
                         output logic stop_ok, output int len);
    logic bits [$];
    int   k = 0;
    len = -1;
    while (k < 100) begin
      if ((k % CPB) == (CPB / 2)) bits.push_back(tx_w[c]);
      if (done_w[c] === 1'b1) begin
        len = k + 1;
        break;
      end
      @(negedge clk);
      k++;
    end
    data = 8'h00;
    for (int i = 0; i < DB[c]; i++)
      if (1 + i < bits.size()) data[i] = bits[1 + i];
    par = ((PE[c] != 0) && (1 + DB[c] < bits.size())) ? bits[1 + DB[c]] : 1'b0;
    stop_ok = (bits.size() == 1 + DB[c] + PE[c] + SB[c]);
    for (int i = 1 + DB[c] + PE[c]; i < bits.size(); i++)
      if (bits[i] !== 1'b1) stop_ok = 1'b0;
    @(negedge clk);
    chk($sformatf("ch%0d_busy_after_done", c), int'(busy_w[c]), 0);
  endtask

  vec_t       vt [10];
  int         n, p0, len, gap, total, it, c, nb;
  logic [7:0] d;
  logic       par, sok;

  initial begin
    vt[0] = '{0, 8'hA5, 1'b0, 40};
    vt[1] = '{0, 8'h3C, 1'b0, 40};
    vt[2] = '{1, 8'h07, 1'b1, 48};
    vt[3] = '{1, 8'h00, 1'b0, 48};
    vt[4] = '{1, 8'hFF, 1'b0, 48};
    vt[5] = '{1, 8'h80, 1'b1, 48};
    vt[6] = '{2, 8'h07, 1'b0, 40};
    vt[7] = '{2, 8'h00, 1'b1, 40};
    vt[8] = '{2, 8'h7F, 1'b0, 40};
    vt[9] = '{2, 8'h55, 1'b1, 40};

    // Power-on reset held 100 cycles.
    #1 rst_n = 1'b0;
    repeat (100) @(negedge clk);
    for (int i = 0; i < NCH; i++)
      chk($sformatf("ch%0d_reset_outputs", i),
          int'({tx_w[i], busy_w[i], done_w[i], rd_w[i]}), 'h8);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      c  = vt[i].ch;
      p0 = pop_cnt[c];
      @(posedge clk); #1 push(c, vt[i].data);
      wait_fall(c, 20, n);
      chk($sformatf("vec%0d_start_latency", i), n, 3);
      capture(c, d, par, sok, len);
      chk($sformatf("vec%0d_data", i), int'(d), int'(vt[i].data));
      if (PE[c] != 0) chk($sformatf("vec%0d_parity", i), int'(par), int'(vt[i].exp_par));
      chk($sformatf("vec%0d_stop_bits", i), int'(sok), 1);
      chk($sformatf("vec%0d_frame_len", i), len, vt[i].exp_len);
      chk($sformatf("vec%0d_pops", i), pop_cnt[c] - p0, 1);
    end

    // Two preloaded bytes go out back to back with a 3-cycle idle gap.
    p0 = pop_cnt[0];
    @(posedge clk); #1 push(0, 8'h00); push(0, 8'hFF);
    wait_fall(0, 20, n);
    capture(0, d, par, sok, len);
    chk("b2b_first_data", int'(d), 'h00);
    gap = 0;
    while ((tx_w[0] === 1'b1) && (gap < 50)) begin
      gap++;
      @(negedge clk);
    end
    chk("b2b_gap_cycles", gap, 3);
    capture(0, d, par, sok, len);
    chk("b2b_second_data", int'(d), 'hFF);
    chk("b2b_second_len", len, 40);
    chk("b2b_pops", pop_cnt[0] - p0, 2);

    // Reset during data bit 3 (bit value 0), next byte waiting when reset releases.
    p0 = pop_cnt[0];
    @(posedge clk); #1 push(0, 8'h35);
    wait_fall(0, 20, n);
    repeat (17) @(negedge clk);
    chk("midframe_tx_before_reset", int'(tx_w[0]), 0);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", int'({tx_w[0], busy_w[0], done_w[0], rd_w[0]}), 'h8);
    push(0, 8'hC3);
    repeat (100) @(negedge clk);
    chk("reset_hold_outputs", int'({tx_w[0], busy_w[0], done_w[0], rd_w[0]}), 'h8);
    @(posedge clk); #1 rst_n = 1'b1;
    wait_fall(0, 20, n);
    chk("post_reset_start_latency", n, 3);
    capture(0, d, par, sok, len);
    chk("post_reset_data", int'(d), 'hC3);
    chk("post_reset_len", len, 40);
    chk("post_reset_pops", pop_cnt[0] - p0, 2);

    // Empty FIFOs for 1000 cycles: no pops, line idle.
    total = pop_cnt[0] + pop_cnt[1] + pop_cnt[2];
    repeat (1000) @(negedge clk);
    chk("idle_no_pops", pop_cnt[0] + pop_cnt[1] + pop_cnt[2], total);
    for (int i = 0; i < NCH; i++)
      chk($sformatf("ch%0d_idle_tx_busy", i), int'({tx_w[i], busy_w[i]}), 'h2);

    // Random bursts on random channels, checked cycle by cycle by the line model.
    for (it = 0; it < 40; it++) begin
      c  = $urandom_range(0, NCH - 1);
      nb = $urandom_range(1, 3);
      @(posedge clk); #1;
      for (int j = 0; j < nb; j++) push(c, 8'($urandom));
      repeat ($urandom_range(0, 60)) @(negedge clk);
    end
    n = 0;
    while (n < 3000 && (fq[0].size() + fq[1].size() + fq[2].size() != 0 ||
                        busy_w[0] || busy_w[1] || busy_w[2])) begin
      @(negedge clk);
      n++;
    end
    chk("random_drain_in_time", int'(n < 3000), 1);
    for (int i = 0; i < NCH; i++)
      chk($sformatf("ch%0d_pops_eq_pushes", i), pop_cnt[i], push_cnt[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
